// File: rtl/yn_capture_pkg.sv
// yn_capture_pkg
// Shared types and default constants for the yn_capture block.
//   state_t        : capture FSM state encoding
//   DEF_DEPTH      : samples captured per run
//   DEF_AW         : address / count width (2**AW must be >= DEPTH)
//   DEF_DW         : sample width
//   DEF_SKIP       : cycles discarded after start to cover datapath latency
package yn_capture_pkg;

    localparam int DEF_DEPTH = 1500;
    localparam int DEF_AW    = 11;
    localparam int DEF_DW    = 8;
    localparam int DEF_SKIP  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SKIP = 2'd1,
        ST_CAPT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/yn_capture_sample_ram.sv
// sample_ram
// Simple dual-port synchronous RAM, DEPTH x DW, one write port and one
// read port on the same clock. Read data is registered (one-cycle latency)
// and is neither reset nor initialised, so the array maps onto block RAM.
//   clk      : clock
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read strobe; rd_data only updates when set
//   rd_addr  : read address
//   rd_data  : registered read data
module sample_ram #(
    parameter int DEPTH = 1500,
    parameter int AW    = 11,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [0:DEPTH-1];
    logic [DW-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/yn_capture.sv
// yn_capture
// Captures DEPTH consecutive filter output samples after a start pulse,
// discarding the first SKIP cycles, then offers the buffer for readback.
//   clk      : clock, all logic on the rising edge
//   n_rst    : asynchronous active-low reset
//   start    : one-cycle run launch pulse (ignored while busy)
//   yn_data  : filter output sample, one per clock
//   busy     : run in progress (SKIP or CAPT)
//   done     : run complete, buffer full
//   wr_cnt   : samples stored in the current run (holds DEPTH when done)
//   rd_en    : readback request, accepted only when not busy
//   rd_addr  : readback address
//   rd_data  : readback sample (0 for out-of-range addresses)
//   rd_vld   : one-cycle qualifier for rd_data
//   rd_err   : out-of-range flag, pulses with rd_vld
module yn_capture
    import yn_capture_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW,
    parameter int SKIP  = DEF_SKIP
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          start,
    input  logic [DW-1:0] yn_data,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] wr_cnt,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_vld,
    output logic          rd_err
);

    // With SKIP=0 the SKIP state is never entered, so the terminal value is moot.
    localparam logic [3:0]  SKIP_LAST = (SKIP > 0) ? 4'(SKIP - 1) : 4'd0;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    // One extra bit so the range check still works when DEPTH == 2**AW.
    localparam logic [AW:0] DEPTH_EXT = (AW + 1)'(DEPTH);

    state_t        state_reg, state_next;
    logic [3:0]    skip_cnt_reg;
    logic [AW-1:0] wr_cnt_reg;
    logic          rd_vld_reg, rd_err_reg;
    logic          idle_or_done;
    logic          start_ok;
    logic          rd_take;
    logic          rd_in_range;
    logic          ram_wr_en;
    logic [DW-1:0] ram_q;

    assign idle_or_done = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
    assign start_ok     = start && idle_or_done;
    // An accepted start takes priority over a simultaneous read request.
    assign rd_take      = rd_en && idle_or_done && !start;
    assign rd_in_range  = {1'b0, rd_addr} < DEPTH_EXT;
    assign ram_wr_en    = (state_reg == ST_CAPT);

    // FSM state register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = (SKIP > 0) ? ST_SKIP : ST_CAPT;
                end
            end
            ST_SKIP: begin
                if (skip_cnt_reg == SKIP_LAST) begin
                    state_next = ST_CAPT;
                end
            end
            ST_CAPT: begin
                if (wr_cnt_reg == LAST_ADDR) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            ST_SKIP, ST_CAPT: busy = 1'b1;
            ST_DONE:          done = 1'b1;
            default:          ;
        endcase
    end

    // Skip and write counters. wr_cnt advances past LAST_ADDR to DEPTH on
    // the final write and then freezes because the FSM leaves CAPT.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            skip_cnt_reg <= '0;
            wr_cnt_reg   <= '0;
        end else if (start_ok) begin
            skip_cnt_reg <= '0;
            wr_cnt_reg   <= '0;
        end else if (state_reg == ST_SKIP) begin
            skip_cnt_reg <= (skip_cnt_reg == SKIP_LAST) ? 4'd0 : skip_cnt_reg + 4'd1;
        end else if (state_reg == ST_CAPT) begin
            wr_cnt_reg <= wr_cnt_reg + 1'b1;
        end
    end

    // Read qualifiers, aligned with the RAM's registered output.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_vld_reg <= 1'b0;
            rd_err_reg <= 1'b0;
        end else begin
            rd_vld_reg <= rd_take;
            rd_err_reg <= rd_take && !rd_in_range;
        end
    end

    sample_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_wr_en),
        .wr_addr (wr_cnt_reg),
        .wr_data (yn_data),
        .rd_en   (rd_take && rd_in_range),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    // The RAM output register is not resettable, so rd_data is forced to
    // zero whenever there is no valid in-range result to present.
    assign rd_data = (rd_vld_reg && !rd_err_reg) ? ram_q : '0;
    assign rd_vld  = rd_vld_reg;
    assign rd_err  = rd_err_reg;
    assign wr_cnt  = wr_cnt_reg;

endmodule

// File: tb/tb_yn_capture.sv
module tb_yn_capture;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [7:0]  yn_data;
    int          cyc = 0;

    // main instance, default parameters
    logic        start, rd_en;
    logic [10:0] rd_addr;
    logic        busy, done, rd_vld, rd_err;
    logic [10:0] wr_cnt;
    logic [7:0]  rd_data;

    // SKIP=0 instance, short buffer
    logic        start0, rd_en0;
    logic [4:0]  rd_addr0;
    logic        busy0, done0, rd_vld0, rd_err0;
    logic [4:0]  wr_cnt0;
    logic [7:0]  rd_data0;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [10:0] addr;
        logic [7:0]  data;
        logic        err;
    } rd_vec_t;

    rd_vec_t vec[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign yn_data = cyc[7:0];

    yn_capture dut (
        .clk(clk), .n_rst(n_rst), .start(start), .yn_data(yn_data),
        .busy(busy), .done(done), .wr_cnt(wr_cnt),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_vld(rd_vld), .rd_err(rd_err)
    );

    yn_capture #(.DEPTH(20), .AW(5), .DW(8), .SKIP(0)) dut0 (
        .clk(clk), .n_rst(n_rst), .start(start0), .yn_data(yn_data),
        .busy(busy0), .done(done0), .wr_cnt(wr_cnt0),
        .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data(rd_data0),
        .rd_vld(rd_vld0), .rd_err(rd_err0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    endtask

    // Word k of a run whose start edge sampled cycle sc.
    function automatic logic [7:0] wexp(input int sc, input int k, input int skip);
        return 8'((sc + skip + 1 + k) % 256);
    endfunction

    function automatic rd_vec_t mk(input int a, input logic [7:0] d, input logic e);
        rd_vec_t v;
        v.addr = 11'(a);
        v.data = d;
        v.err  = e;
        return v;
    endfunction

    // Back-to-back reads of every vector in vec; sel picks the SKIP=0 instance.
    task automatic apply_vec(input bit sel);
        logic [7:0] d;
        logic       v, e;
        for (int i = 0; i < vec.size(); i++) begin
            if (sel) begin rd_en0 = 1'b1; rd_addr0 = vec[i].addr[4:0]; end
            else     begin rd_en  = 1'b1; rd_addr  = vec[i].addr;      end
            @(negedge clk);
            d = sel ? rd_data0 : rd_data;
            v = sel ? rd_vld0  : rd_vld;
            e = sel ? rd_err0  : rd_err;
            $display("rd dut%0s addr=%0d data=%0d vld=%0b err=%0b", sel ? "0" : "",
                     vec[i].addr, d, v, e);
            chk("rd_vld", 32'(v), 1);
            chk("rd_data", 32'(d), 32'(vec[i].data));
            chk("rd_err", 32'(e), 32'(vec[i].err));
        end
        rd_en = 1'b0; rd_en0 = 1'b0;
        @(negedge clk);
        chk("rd_vld_idle", 32'(sel ? rd_vld0 : rd_vld), 0);
        chk("rd_data_idle", 32'(sel ? rd_data0 : rd_data), 0);
    endtask

    // Wait for done with a cycle budget; returns busy cycles seen.
    task automatic wait_done(input bit sel, output int busy_cnt);
        int g;
        busy_cnt = 0;
        g = 0;
        while (!(sel ? done0 : done) && g < 4000) begin
            if (sel ? busy0 : busy) busy_cnt++;
            g++;
            @(negedge clk);
        end
        chk("done_timeout", 32'(sel ? done0 : done), 1);
    endtask

    initial begin
        int sc1, sc2, sc3, sc0, busy_cnt, bad_vld, i, g;
        start = 0; rd_en = 0; rd_addr = '0;
        start0 = 0; rd_en0 = 0; rd_addr0 = '0;
        n_rst = 1'b1;
        #1 n_rst = 1'b0;
        #2;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_wr_cnt", 32'(wr_cnt), 0);
        chk("rst_rd_vld", 32'(rd_vld), 0);
        chk("rst_rd_err", 32'(rd_err), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        #4 n_rst = 1'b1;                        // t=7

        // ---- run 1: start 20..30, rd_en held during busy, second start at sample 700
        @(negedge clk);                         // t=10
        @(negedge clk);                         // t=20
        start = 1'b1; sc1 = cyc;
        @(negedge clk);
        start = 1'b0;
        $display("run1 start sc=%0d", sc1);
        chk("run1_busy", 32'(busy), 1);
        chk("run1_done", 32'(done), 0);
        busy_cnt = 0; bad_vld = 0; i = 0;
        while (!done && i < 4000) begin
            if (busy) busy_cnt++;
            if (rd_vld) bad_vld++;
            if (i < 4) chk("run1_wr_cnt_early", 32'(wr_cnt), (i == 3) ? 1 : 0);
            start = (wr_cnt == 11'd700);
            rd_en = 1'b1; rd_addr = 11'd5;
            i++;
            @(negedge clk);
        end
        rd_en = 1'b0; start = 1'b0;
        chk("run1_done_timeout", 32'(done), 1);
        chk("run1_busy_cycles", 32'(busy_cnt), 1502);
        chk("run1_rd_vld_while_busy", 32'(bad_vld), 0);
        chk("run1_wr_cnt", 32'(wr_cnt), 1500);
        chk("run1_busy_end", 32'(busy), 0);

        vec.delete();
        foreach (vec[j]) vec.delete(j);
        vec.push_back(mk(0,    wexp(sc1, 0,    2), 1'b0));
        vec.push_back(mk(1,    wexp(sc1, 1,    2), 1'b0));
        vec.push_back(mk(255,  wexp(sc1, 255,  2), 1'b0));
        vec.push_back(mk(699,  wexp(sc1, 699,  2), 1'b0));
        vec.push_back(mk(700,  wexp(sc1, 700,  2), 1'b0));
        vec.push_back(mk(701,  wexp(sc1, 701,  2), 1'b0));
        vec.push_back(mk(1499, wexp(sc1, 1499, 2), 1'b0));
        vec.push_back(mk(1500, 8'd0, 1'b1));
        vec.push_back(mk(2047, 8'd0, 1'b1));
        apply_vec(1'b0);

        // ---- run 2: start in DONE with simultaneous rd_en, reset at sample 300
        start = 1'b1; rd_en = 1'b1; rd_addr = 11'd3; sc2 = cyc;
        @(negedge clk);
        start = 1'b0; rd_en = 1'b0;
        $display("run2 start sc=%0d", sc2);
        chk("run2_rd_vld_start_wins", 32'(rd_vld), 0);
        chk("run2_done_drop", 32'(done), 0);
        chk("run2_busy", 32'(busy), 1);
        chk("run2_wr_cnt_clear", 32'(wr_cnt), 0);
        g = 0;
        while (wr_cnt != 11'd300 && g < 2000) begin g++; @(negedge clk); end
        chk("run2_reach_300", 32'(wr_cnt), 300);
        n_rst = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_wr_cnt", 32'(wr_cnt), 0);
        chk("mid_rst_rd_vld", 32'(rd_vld), 0);
        chk("mid_rst_rd_err", 32'(rd_err), 0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 32'(busy), 0);

        // ---- run 3: fresh run, ramp offset differs from run 1 by 100
        g = 0;
        while (((cyc - sc1) & 255) != 100 && g < 300) begin g++; @(negedge clk); end
        start = 1'b1; sc3 = cyc;
        @(negedge clk);
        start = 1'b0;
        $display("run3 start sc=%0d", sc3);
        chk("run3_wr_cnt_start", 32'(wr_cnt), 0);
        wait_done(1'b0, busy_cnt);
        chk("run3_busy_cycles", 32'(busy_cnt), 1502);
        chk("run3_wr_cnt", 32'(wr_cnt), 1500);
        vec.delete();
        vec.push_back(mk(0,    wexp(sc3, 0,    2), 1'b0));
        vec.push_back(mk(299,  wexp(sc3, 299,  2), 1'b0));
        vec.push_back(mk(300,  wexp(sc3, 300,  2), 1'b0));
        vec.push_back(mk(1499, wexp(sc3, 1499, 2), 1'b0));
        apply_vec(1'b0);

        // ---- SKIP=0 instance: word 0 is the sample of the cycle after start
        start0 = 1'b1; sc0 = cyc;
        @(negedge clk);
        start0 = 1'b0;
        $display("skip0 start sc=%0d", sc0);
        chk("skip0_busy", 32'(busy0), 1);
        chk("skip0_wr_cnt0", 32'(wr_cnt0), 0);
        @(negedge clk);
        chk("skip0_wr_cnt1", 32'(wr_cnt0), 1);
        wait_done(1'b1, busy_cnt);
        chk("skip0_busy_cycles", 32'(busy_cnt), 19);
        chk("skip0_wr_cnt", 32'(wr_cnt0), 20);
        vec.delete();
        vec.push_back(mk(0,  wexp(sc0, 0,  0), 1'b0));
        vec.push_back(mk(19, wexp(sc0, 19, 0), 1'b0));
        vec.push_back(mk(20, 8'd0, 1'b1));
        vec.push_back(mk(31, 8'd0, 1'b1));
        apply_vec(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/yn_capture.md
YN_CAPTURE -- requirements
Module: yn_capture

Interface
REQ-001 Parameter DEPTH, default 1500, number of output samples captured per run.
REQ-002 Parameter AW, default 11, address/count width; SHALL satisfy 2**AW >= DEPTH.
REQ-003 Parameter DW, default 8, sample width.
REQ-004 Parameter SKIP, default 2, cycles discarded after start to cover datapath latency; range 0..15.
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 n_rst  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle pulse, same pulse that launches the xn_data stream into top.
REQ-008 yn_data  input  DW  filter output sample, one new sample per clk.
REQ-009 busy  output  1  high in SKIP or CAPT state.
REQ-010 done  output  1  high in DONE state.
REQ-011 wr_cnt  output  AW  number of samples stored in the current run.
REQ-012 rd_en  input  1  readback request, one per cycle.
REQ-013 rd_addr  input  AW  readback address.
REQ-014 rd_data  output  DW  readback sample.
REQ-015 rd_vld  output  1  rd_data qualifier, one cycle.
REQ-016 rd_err  output  1  pulses with rd_vld when rd_addr >= DEPTH.

Function
REQ-017 FSM states IDLE, SKIP, CAPT, DONE; reset state IDLE.
REQ-018 IDLE or DONE with start=1 -> SKIP if SKIP>0, else CAPT; wr_cnt cleared to 0 and done cleared on that edge.
REQ-019 SKIP: skip counter counts SKIP cycles, yn_data ignored; exits to CAPT after the SKIP-th cycle.
REQ-020 CAPT: each cycle writes yn_data to address wr_cnt, wr_cnt increments by 1.
REQ-021 CAPT -> DONE on the cycle the write to address DEPTH-1 occurs; wr_cnt then holds DEPTH and stops.
REQ-022 Sample captured at CAPT cycle k (k=0..DEPTH-1) is the yn_data value present k+SKIP+1 clocks after the start edge.
REQ-023 start while busy=1 SHALL be ignored; the run is not restarted.
REQ-024 rd_en accepted only in IDLE or DONE; while busy, rd_en is ignored and rd_vld stays 0.
REQ-025 Read latency exactly 1 cycle: rd_en at edge N -> rd_vld=1, rd_data valid after edge N+1.
REQ-026 rd_addr >= DEPTH: rd_data=0, rd_vld=1, rd_err=1; no memory access.
REQ-027 Back-to-back rd_en every cycle SHALL return one result per cycle, in order.
REQ-028 rd_en in the same cycle as an accepted start is ignored (start wins).
REQ-029 Reading addresses >= wr_cnt returns stale memory contents, rd_err=0.

Reset
REQ-030 n_rst=0 asynchronously forces: state IDLE, busy=0, done=0, wr_cnt=0, skip counter 0, rd_vld=0, rd_err=0, rd_data=0.
REQ-031 Memory contents not reset; reset mid-capture abandons the run, next start begins at address 0.
REQ-032 Reset deassertion is synchronized by the system; no start is expected in the first cycle after release.

Structure
REQ-033 Package yn_capture_pkg holds state enum type and default constants DEPTH/AW/DW/SKIP.
REQ-034 One sub-module sample_ram: single-port-write/single-port-read synchronous RAM, DEPTH x DW, registered read output.
REQ-035 FSM, counters and read-port logic live in yn_capture; no combinational path yn_data -> any output.

Verification
REQ-036 Reset at t=7, start pulse 20..30, yn_data = 8-bit ramp (cycle index) -> busy 2 cycles SKIP + 1500 CAPT, done=1, wr_cnt=1500; readback addr k returns (k+start_cycle+3) mod 256.
REQ-037 SKIP=0 variant: word 0 equals yn_data of the cycle immediately after start.
REQ-038 Second start pulse at capture sample 700 -> ignored; done still asserts after 1500 samples, data unaffected.
REQ-039 rd_en during busy -> rd_vld never asserts; after done, rd_en 1499,1500,2047 back-to-back -> valid data, then rd_err=1 twice with rd_data=0.
REQ-040 n_rst pulse low at sample 300 -> all outputs reset same cycle; new start captures fresh run, wr_cnt restarts at 0.
REQ-041 start in DONE -> done drops next edge, wr_cnt=0, new run overwrites buffer with new ramp values.
